// File: rtl/raizing_textrom_arbiter.sv
// rtl/raizing_textrom_arbiter.sv - two-port round-robin arbiter sharing one text-ROM read port
module raizing_textrom_arbiter #(
    parameter int unsigned AW      = 14,
    parameter int unsigned DW      = 16,
    parameter int unsigned LAT     = 2,
    parameter bit          A_FIRST = 1'b1
) (
    input  logic          CLK96,
    input  logic          RESET96,
    input  logic          SUSPEND,
    input  logic          A_REQ,
    input  logic [AW-1:0] A_ADDR,
    output logic          A_GNT,
    output logic          A_DV,
    output logic [DW-1:0] A_DATA,
    input  logic          B_REQ,
    input  logic [AW-1:0] B_ADDR,
    output logic          B_GNT,
    output logic          B_DV,
    output logic [DW-1:0] B_DATA,
    output logic          MEM_RD,
    output logic [AW-1:0] MEM_ADDR,
    input  logic [DW-1:0] MEM_DATA,
    output logic          BUSY
);

    // last_b_q = 1 means B won the previous grant, so the next tie goes to A.
    // Reset value equals A_FIRST so the first tie goes to the A_FIRST port.
    logic          last_b_q, last_b_d;
    logic          mem_rd_q, mem_rd_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    // Tag pipe: stage i holds {valid, port} of the read issued i cycles after MEM_RD.
    logic [LAT:0]  tag_vld_q, tag_vld_d;
    logic [LAT:0]  tag_b_q, tag_b_d;
    logic          a_dv_q, a_dv_d;
    logic          b_dv_q, b_dv_d;
    logic [DW-1:0] a_data_q, a_data_d;
    logic [DW-1:0] b_data_q, b_data_d;
    logic          grant_a, grant_b;
    logic          issue;

    // Combinational arbitration: single requester wins, ties go to the port not granted last.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!SUSPEND) begin
            if (A_REQ && (!B_REQ || last_b_q)) begin
                grant_a = 1'b1;
            end else if (B_REQ) begin
                grant_b = 1'b1;
            end
        end
    end

    assign issue = grant_a | grant_b;

    // Next-state: issue strobe/address, tag shift, and delivery to the tagged port.
    always_comb begin
        last_b_d   = last_b_q;
        mem_rd_d   = issue;
        mem_addr_d = mem_addr_q;
        a_data_d   = a_data_q;
        b_data_d   = b_data_q;
        if (issue) begin
            last_b_d   = grant_b;
            mem_addr_d = grant_a ? A_ADDR : B_ADDR;
        end
        tag_vld_d = {tag_vld_q[LAT-1:0], issue};
        tag_b_d   = {tag_b_q[LAT-1:0], grant_b};
        // Stage LAT lines up with the cycle in which MEM_DATA is valid.
        a_dv_d = tag_vld_q[LAT] & ~tag_b_q[LAT];
        b_dv_d = tag_vld_q[LAT] &  tag_b_q[LAT];
        if (a_dv_d) begin
            a_data_d = MEM_DATA;
        end
        if (b_dv_d) begin
            b_data_d = MEM_DATA;
        end
    end

    // State registers; reset drops every in-flight tag so no stale data is delivered.
    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) begin
            last_b_q   <= A_FIRST;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            tag_vld_q  <= '0;
            tag_b_q    <= '0;
            a_dv_q     <= 1'b0;
            b_dv_q     <= 1'b0;
            a_data_q   <= '0;
            b_data_q   <= '0;
        end else begin
            last_b_q   <= last_b_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            tag_vld_q  <= tag_vld_d;
            tag_b_q    <= tag_b_d;
            a_dv_q     <= a_dv_d;
            b_dv_q     <= b_dv_d;
            a_data_q   <= a_data_d;
            b_data_q   <= b_data_d;
        end
    end

    assign A_GNT    = grant_a;
    assign B_GNT    = grant_b;
    assign MEM_RD   = mem_rd_q;
    assign MEM_ADDR = mem_addr_q;
    assign A_DV     = a_dv_q;
    assign B_DV     = b_dv_q;
    assign A_DATA   = a_data_q;
    assign B_DATA   = b_data_q;
    assign BUSY     = |tag_vld_q;

endmodule

// File: tb/tb_raizing_textrom_arbiter.sv
// tb/tb_raizing_textrom_arbiter.sv - self-checking bench for raizing_textrom_arbiter
module tb_raizing_textrom_arbiter;

    localparam int N = 5;

    logic CLK96 = 1'b0;
    always #5 CLK96 = ~CLK96;

    logic         RESET96;
    logic [N-1:0] suspend, a_req, b_req, a_gnt, b_gnt, a_dv, b_dv, mem_rd, busy;
    logic [13:0]  a_addr [N];
    logic [13:0]  b_addr [N];
    logic [13:0]  mem_addr [N];
    logic [15:0]  a_data [N];
    logic [15:0]  b_data [N];
    logic [15:0]  mem_data [N];

    // Instances 0..3: LAT 1..4 with A_FIRST=1; instance 4: LAT 2 with A_FIRST=0.
    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_dut
            localparam int L = (g == 4) ? 2 : g + 1;
            logic [15:0] mp [4];
            raizing_textrom_arbiter #(
                .AW(14), .DW(16), .LAT(L), .A_FIRST((g == 4) ? 1'b0 : 1'b1)
            ) u_dut (
                .CLK96(CLK96), .RESET96(RESET96), .SUSPEND(suspend[g]),
                .A_REQ(a_req[g]), .A_ADDR(a_addr[g]), .A_GNT(a_gnt[g]),
                .A_DV(a_dv[g]), .A_DATA(a_data[g]),
                .B_REQ(b_req[g]), .B_ADDR(b_addr[g]), .B_GNT(b_gnt[g]),
                .B_DV(b_dv[g]), .B_DATA(b_data[g]),
                .MEM_RD(mem_rd[g]), .MEM_ADDR(mem_addr[g]), .MEM_DATA(mem_data[g]),
                .BUSY(busy[g])
            );
            // ROM model: data = addr ^ 0xA5A5, valid exactly L cycles after the MEM_RD cycle, junk otherwise.
            always @(posedge CLK96) begin
                mp[0] <= mem_rd[g] ? ({2'b00, mem_addr[g]} ^ 16'hA5A5) : 16'($urandom);
                for (int i = 1; i < 4; i++) mp[i] <= mp[i-1];
            end
            assign mem_data[g] = mp[L-1];
        end
    endgenerate

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    int          idx, cur_lat, cyc, last_issue;
    bit          prefer_a, rd_exp, mg_a, mg_b;
    logic [13:0] addr_exp;
    logic [15:0] a_hold, b_hold;
    exp_t        qa[$];
    exp_t        qb[$];
    int          glog[$];
    int          dv_a_cnt, dv_b_cnt;

    function automatic int lat_of(input int i);
        return (i == 4) ? 2 : i + 1;
    endfunction

    function automatic bit af_of(input int i);
        return (i == 4) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic [15:0] d_of(input logic [13:0] a);
        return {2'b00, a} ^ 16'hA5A5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (inst %0d cycle %0d)", tag, obs, exp, idx, cyc);
        end
    endtask

    // Asynchronous reset of all instances; outputs of the active one are checked before any clock edge.
    task automatic do_reset(input int i);
        idx     = i;
        cur_lat = lat_of(i);
        a_req   = '0;
        b_req   = '0;
        suspend = '0;
        RESET96 = 1'b1;
        #1;
        chk("rst_mem_rd", mem_rd[idx], 0);
        chk("rst_mem_addr", mem_addr[idx], 0);
        chk("rst_a_dv", a_dv[idx], 0);
        chk("rst_b_dv", b_dv[idx], 0);
        chk("rst_a_data", a_data[idx], 0);
        chk("rst_b_data", b_data[idx], 0);
        chk("rst_busy", busy[idx], 0);
        @(posedge CLK96);
        #1;
        cyc++;
        RESET96    = 1'b0;
        prefer_a   = af_of(i);
        last_issue = -1000;
        rd_exp     = 1'b0;
        addr_exp   = '0;
        a_hold     = '0;
        b_hold     = '0;
        dv_a_cnt   = 0;
        dv_b_cnt   = 0;
        qa.delete();
        qb.delete();
        glog.delete();
    endtask

    // One clock cycle on the active instance, checked against the reference model.
    task automatic step(input bit ar, input logic [13:0] aa, input bit br, input logic [13:0] ba, input bit sus);
        bit   ga, gb;
        exp_t e;
        a_req[idx]   = ar;
        a_addr[idx]  = aa;
        b_req[idx]   = br;
        b_addr[idx]  = ba;
        suspend[idx] = sus;
        #1;
        ga = !sus && ar && (!br || prefer_a);
        gb = !sus && br && !ga;
        chk("a_gnt", a_gnt[idx], ga);
        chk("b_gnt", b_gnt[idx], gb);
        glog.push_back(a_gnt[idx] ? 0 : (b_gnt[idx] ? 1 : 2));
        mg_a = ga;
        mg_b = gb;
        if (ga || gb) begin
            prefer_a   = gb;
            addr_exp   = ga ? aa : ba;
            rd_exp     = 1'b1;
            last_issue = cyc + 1;
            e.cyc      = cyc + cur_lat + 2;
            e.data     = d_of(addr_exp);
            if (ga) qa.push_back(e);
            else    qb.push_back(e);
        end else begin
            rd_exp = 1'b0;
        end
        @(posedge CLK96);
        #1;
        cyc++;
        chk("mem_rd", mem_rd[idx], rd_exp);
        chk("mem_addr", mem_addr[idx], addr_exp);
        chk("busy", busy[idx], (cyc - last_issue <= cur_lat));
        if (qa.size() > 0 && qa[0].cyc == cyc) begin
            chk("a_dv", a_dv[idx], 1);
            chk("a_data", a_data[idx], qa[0].data);
            a_hold = qa[0].data;
            void'(qa.pop_front());
        end else begin
            chk("a_dv", a_dv[idx], 0);
            chk("a_data_hold", a_data[idx], a_hold);
        end
        if (qb.size() > 0 && qb[0].cyc == cyc) begin
            chk("b_dv", b_dv[idx], 1);
            chk("b_data", b_data[idx], qb[0].data);
            b_hold = qb[0].data;
            void'(qb.pop_front());
        end else begin
            chk("b_dv", b_dv[idx], 0);
            chk("b_data_hold", b_data[idx], b_hold);
        end
        if (a_dv[idx]) dv_a_cnt++;
        if (b_dv[idx]) dv_b_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 14'h0, 1'b0, 14'h0, 1'b0);
    endtask

    initial begin
        bit          ar, br;
        logic [13:0] aa, ba;
        int          na, nb, wa, wb, max_wait;
        cyc     = 0;
        RESET96 = 1'b1;
        a_req   = '0;
        b_req   = '0;
        suspend = '0;
        for (int i = 0; i < N; i++) begin
            a_addr[i] = '0;
            b_addr[i] = '0;
        end
        repeat (2) @(posedge CLK96);
        #1;

        // Single A read at LAT=2.
        do_reset(1);
        step(1'b1, 14'h0123, 1'b0, 14'h0, 1'b0);
        idle(3);
        chk("t1_a_dv", a_dv[1], 1);
        chk("t1_a_data", a_data[1], 16'hA486);
        chk("t1_b_dv", b_dv[1], 0);
        idle(2);

        // Both ports requesting continuously: strict alternation starting with A.
        do_reset(1);
        na = 0;
        nb = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 14'(14'h100 + na), 1'b1, 14'(14'h200 + nb), 1'b0);
            if (mg_a) na++;
            if (mg_b) nb++;
        end
        idle(4);
        for (int i = 0; i < 8; i++) chk("t2_order", glog[i], i % 2);
        chk("t2_dv_a_cnt", dv_a_cnt, 4);
        chk("t2_dv_b_cnt", dv_b_cnt, 4);

        // First tie after reset follows A_FIRST.
        do_reset(4);
        step(1'b1, 14'h0011, 1'b1, 14'h0022, 1'b0);
        chk("t3_first_af0", glog[0], 1);
        idle(4);
        do_reset(1);
        step(1'b1, 14'h0011, 1'b1, 14'h0022, 1'b0);
        chk("t3_first_af1", glog[0], 0);
        idle(4);

        // SUSPEND two cycles into a stream: in-flight reads finish, nothing new issues.
        do_reset(1);
        step(1'b1, 14'h0040, 1'b1, 14'h0050, 1'b0);
        step(1'b1, 14'h0041, 1'b1, 14'h0050, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 14'h0041, 1'b1, 14'h0051, 1'b1);
        chk("t4_busy_low", busy[1], 0);
        chk("t4_dv_a_cnt", dv_a_cnt, 1);
        chk("t4_dv_b_cnt", dv_b_cnt, 1);
        step(1'b1, 14'h0041, 1'b1, 14'h0051, 1'b0);
        chk("t4_resume_a", glog[glog.size()-1], 0);
        idle(4);

        // Reset with two reads in flight: nothing is delivered afterwards.
        do_reset(1);
        step(1'b1, 14'h0031, 1'b0, 14'h0, 1'b0);
        step(1'b0, 14'h0, 1'b1, 14'h0032, 1'b0);
        chk("t5_busy_pre", busy[1], 1);
        do_reset(1);
        idle(5);
        chk("t5_no_dv_a", dv_a_cnt, 0);
        chk("t5_no_dv_b", dv_b_cnt, 0);

        // Random traffic on LAT=1..4; requesters hold REQ until granted.
        for (int inst = 0; inst < 4; inst++) begin
            do_reset(inst);
            ar       = 1'b0;
            br       = 1'b0;
            aa       = '0;
            ba       = '0;
            wa       = 0;
            wb       = 0;
            max_wait = 0;
            for (int c = 0; c < 2500; c++) begin
                if (!ar && $urandom_range(0, 1) == 1) begin ar = 1'b1; aa = 14'($urandom); end
                if (!br && $urandom_range(0, 1) == 1) begin br = 1'b1; ba = 14'($urandom); end
                step(ar, aa, br, ba, 1'b0);
                if (ar && !a_gnt[idx]) wa++; else wa = 0;
                if (br && !b_gnt[idx]) wb++; else wb = 0;
                if (wa > max_wait) max_wait = wa;
                if (wb > max_wait) max_wait = wb;
                if (mg_a) begin ar = ($urandom_range(0, 3) != 0); aa = 14'($urandom); end
                if (mg_b) begin br = ($urandom_range(0, 3) != 0); ba = 14'($urandom); end
            end
            idle(cur_lat + 2);
            checks++;
            assert (max_wait <= 1) else begin
                errors++;
                $error("FAIL max_wait: observed %0d required <=1 (inst %0d)", max_wait, inst);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
